sfx_voice_scheduler: RTL

Schedules the discrete sound voices (bonus, jump, walk, death, …) from the CPU sound-latch bits and mixes their outputs. It turns raw latch levels into per-voice enables with a guaranteed minimum on-time and tracks each voice's decay tail. It also limits how many voices sound at once using fixed priority and pre-emption. It sits between the sound latch and the audio output, running on the shared 48 kHz tick.

---
 rtl/sfx_pkg.sv | 14 +
 rtl/sfx_voice_slot.sv | 83 ++++++++
 rtl/sfx_voice_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// Shared types and widths for the discrete sound-effect voice scheduler.
// Voice FSM state encoding plus sample/timer widths.
package sfx_pkg;

   localparam int SFX_SAMPLE_W = 16;
   localparam int SFX_TIMER_W  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      RELEASE = 2'd2
   } voice_state_t;

endpackage

// File: rtl/sfx_voice_slot.sv
// One voice: IDLE/ACTIVE/RELEASE FSM with minimum on-time and decay tail.
// All state advances only on the shared sample tick.
module sfx_voice_slot
   import sfx_pkg::*;
#(
   parameter int MIN_ON_TICKS = 1452,
   parameter int TAIL_TICKS   = 1344
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic req,
   input  logic grant,
   input  logic preempt,
   input  logic trig_level,
   output logic occupied,
   output logic en
);

   localparam logic [SFX_TIMER_W-1:0] ON_LOAD   = SFX_TIMER_W'(MIN_ON_TICKS - 1);
   localparam logic [SFX_TIMER_W-1:0] TAIL_LOAD = SFX_TIMER_W'(TAIL_TICKS - 1);

   voice_state_t           state_q, state_d;
   logic [SFX_TIMER_W-1:0] on_q, on_d;
   logic [SFX_TIMER_W-1:0] tail_q, tail_d;

   // State and timers move only on ticks; reset wins over the tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         on_q    <= '0;
         tail_q  <= '0;
      end else if (tick) begin
         state_q <= state_d;
         on_q    <= on_d;
         tail_q  <= tail_d;
      end
   end

   // Next state: pre-emption overrides everything else in the slot.
   always_comb begin
      state_d = state_q;
      on_d    = on_q;
      tail_d  = tail_q;
      if (preempt) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant) begin
                  state_d = ACTIVE;
                  on_d    = ON_LOAD;
               end
            end
            ACTIVE: begin
               if (req) begin
                  on_d = ON_LOAD;
               end else if (on_q != '0) begin
                  on_d = on_q - 1'b1;
               end else if (!trig_level) begin
                  state_d = RELEASE;
                  tail_d  = TAIL_LOAD;
               end
            end
            RELEASE: begin
               if (req) begin
                  state_d = ACTIVE;
                  on_d    = ON_LOAD;
               end else if (tail_q != '0) begin
                  tail_d = tail_q - 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign occupied = (state_q != IDLE);
   assign en       = (state_q == ACTIVE);

endmodule

// File: rtl/sfx_voice_scheduler.sv
// Sound-latch voice scheduler: edge detect, priority/pre-emption, mixing.
// Lower voice index always wins; the mix is saturated to 16 bits.
module sfx_voice_scheduler
   import sfx_pkg::*;
#(
   parameter int NUM_VOICES   = 4,
   parameter int MAX_ACTIVE   = 2,
   parameter int MIN_ON_TICKS = 1452,
   parameter int TAIL_TICKS   = 1344,
   parameter int GAIN_SHIFT   = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               clk_48KHz_en,
   input  logic [NUM_VOICES-1:0]              trig,
   input  logic [SFX_SAMPLE_W*NUM_VOICES-1:0] voice_audio,
   output logic [NUM_VOICES-1:0]              voice_en,
   output logic [SFX_SAMPLE_W-1:0]            audio_out,
   output logic                               busy
);

   localparam int SUM_W = SFX_SAMPLE_W + $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(NUM_VOICES + 1);

   logic [NUM_VOICES-1:0]   trig_q;
   logic [NUM_VOICES-1:0]   req;
   logic [NUM_VOICES-1:0]   grant;
   logic [NUM_VOICES-1:0]   preempt;
   logic [NUM_VOICES-1:0]   occupied;
   logic [NUM_VOICES-1:0]   occ_w;
   logic [CNT_W-1:0]        cnt_w;
   logic                    found;
   logic [SUM_W-1:0]        sum;
   logic [SUM_W-1:0]        shifted;
   logic [SFX_SAMPLE_W-1:0] mix_sat;

   assign req = trig & ~trig_q;

   // Resolve requests in index order against the running occupancy.
   always_comb begin
      grant   = '0;
      preempt = '0;
      occ_w   = occupied;
      cnt_w   = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         cnt_w = cnt_w + CNT_W'(occupied[i]);
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (req[i] && !occupied[i] && !preempt[i]) begin
            if (cnt_w < CNT_W'(MAX_ACTIVE)) begin
               grant[i] = 1'b1;
               occ_w[i] = 1'b1;
               cnt_w    = cnt_w + 1'b1;
            end else begin
               found = 1'b0;
               for (int j = NUM_VOICES - 1; j >= 0; j--) begin
                  if (j > i && !found && occ_w[j]) begin
                     found      = 1'b1;
                     preempt[j] = 1'b1;
                     occ_w[j]   = 1'b0;
                  end
               end
               if (found) begin
                  grant[i] = 1'b1;
                  occ_w[i] = 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
      sfx_voice_slot #(
         .MIN_ON_TICKS (MIN_ON_TICKS),
         .TAIL_TICKS   (TAIL_TICKS)
      ) u_slot (
         .clk        (clk),
         .reset      (reset),
         .tick       (clk_48KHz_en),
         .req        (req[g]),
         .grant      (grant[g]),
         .preempt    (preempt[g]),
         .trig_level (trig[g]),
         .occupied   (occupied[g]),
         .en         (voice_en[g])
      );
   end

   // Sum the voices occupied before this tick's update, then saturate.
   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (occupied[i]) begin
            sum = sum + SUM_W'(voice_audio[SFX_SAMPLE_W*i +: SFX_SAMPLE_W]);
         end
      end
      shifted = sum >> GAIN_SHIFT;
      mix_sat = (shifted > SUM_W'(16'hFFFF)) ? 16'hFFFF : shifted[SFX_SAMPLE_W-1:0];
   end

   // Trig history and mixed sample update on ticks only.
   always_ff @(posedge clk) begin
      if (reset) begin
         trig_q    <= '0;
         audio_out <= '0;
      end else if (clk_48KHz_en) begin
         trig_q    <= trig;
         audio_out <= mix_sat;
      end
   end

   assign busy = |occupied;

endmodule
